csa_add_pipe: RTL and testbench

Parametrised, pipelined multi-operand adder with valid/ready flow control. It reduces M unsigned N-bit operands plus a carry-in through rows of 3:2 carry-save compressors, then performs one carry-propagate add. It is the general-width, general-operand-count successor of the fixed three-operand adder used in the modular-squaring datapath. It also carries a sideband tag so that upstream reduction logic can match results to requests.

---
 rtl/csa_add_pkg.sv | 41 ++++
 rtl/csa_row.sv | 19 +
 rtl/csa_add_pipe.sv | 148 ++++++++++++++
 tb/tb_csa_add_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_add_pkg.sv
// Shared sizing helpers for the pipelined carry-save multi-operand adder.
// Level tables are computed at elaboration time from the operand count.
package csa_add_pkg;

  // Operand count entering compressor level k (k = 0 is the raw operand set)
  function automatic int level_ops(int m, int k);
    int c;
    c = m;
    for (int i = 0; i < k; i++) begin
      c = 2 * (c / 3) + (c % 3);
    end
    return c;
  endfunction

  function automatic int levels(int m);
    int c;
    int n;
    c = m;
    n = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + (c % 3);
      n++;
    end
    return n;
  endfunction

  function automatic int out_width(int n, int m);
    return n + $clog2(m);
  endfunction

  // Start index of level k inside a flat vector bus holding every level back to back
  function automatic int ops_offset(int m, int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) begin
      s += level_ops(m, j);
    end
    return s;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One W-bit 3:2 compressor row; ci_i fills bit 0 of the shifted carry vector.
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] cy_o
);

  logic [W-1:0] maj;

  assign s_o  = a_i ^ b_i ^ c_i;
  assign maj  = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign cy_o = (maj << 1) | W'(ci_i);

endmodule

// File: rtl/csa_add_pipe.sv
// Elastic multi-operand adder: input register, carry-save tree, carry-propagate output register.
// Define CSA_ADD_LEVEL_REG_EN to register after every compressor level.
module csa_add_pipe
  import csa_add_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned M      = 4,
  parameter int unsigned TAG_W  = 8,
  localparam int unsigned OW    = out_width(N, M)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M-1:0][N-1:0] ops_in,
  input  logic                carry_in,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OW-1:0]       sum_out,
  output logic [TAG_W-1:0]    tag_out
);

  localparam int unsigned L  = levels(M);
  localparam int unsigned NV = ops_offset(M, L + 1);
  localparam int unsigned FB = ops_offset(M, L);
`ifdef CSA_ADD_LEVEL_REG_EN
  localparam int unsigned D  = L + 2;
`else
  localparam int unsigned D  = 2;
`endif

  logic [D-1:0] vld_q;
  logic [D-1:0] vld_d;
  logic [D-1:0] rdy_c;
  logic [D-1:0] up_vld_c;
  logic [D-1:0] ld_c;

  // A stage is ready when empty or when everything downstream lets it drain
  always_comb begin
    logic ok;
    ok    = out_ready;
    rdy_c = '0;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      ok       = !vld_q[i] || ok;
      rdy_c[i] = ok;
    end
  end

  assign up_vld_c = {vld_q[D-2:0], in_valid};
  assign ld_c     = rdy_c & up_vld_c;
  assign vld_d    = ld_c | (vld_q & ~rdy_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign in_ready  = rdy_c[0];
  assign out_valid = vld_q[D-1];

  logic [M-1:0][N-1:0] s0_ops_q;
  logic                s0_cin_q;
  logic [TAG_W-1:0]    s0_tag_q;

  always_ff @(posedge clk) begin
    if (ld_c[0]) begin
      s0_ops_q <= ops_in;
      s0_cin_q <= carry_in;
      s0_tag_q <= tag_in;
    end
  end

  // vec: inputs of every level back to back; nxt_c: raw outputs of levels 0..L-1
  logic [NV-1:0][OW-1:0]   vec;
  logic [NV-M-1:0][OW-1:0] nxt_c;

  for (genvar i = 0; i < M; i++) begin : g_op
    assign vec[i] = OW'(s0_ops_q[i]);
  end

`ifdef CSA_ADD_LEVEL_REG_EN
  logic [L:0][TAG_W-1:0] tag_v;
  assign tag_v[0] = s0_tag_q;
`endif

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned CI = level_ops(M, k);
    localparam int unsigned CO = level_ops(M, k + 1);
    localparam int unsigned T  = CI / 3;
    localparam int unsigned IB = ops_offset(M, k);
    localparam int unsigned OB = ops_offset(M, k + 1);

    for (genvar t = 0; t < T; t++) begin : g_row
      csa_row #(.W(OW)) u_row (
        .a_i  (vec[IB + 3*t]),
        .b_i  (vec[IB + 3*t + 1]),
        .c_i  (vec[IB + 3*t + 2]),
        .ci_i ((k == 0 && t == 0) ? s0_cin_q : 1'b0),
        .s_o  (nxt_c[OB - M + 2*t]),
        .cy_o (nxt_c[OB - M + 2*t + 1])
      );
    end

    // Leftover operands skip this level unchanged
    for (genvar r = 0; r < CI - 3*T; r++) begin : g_pass
      assign nxt_c[OB - M + 2*T + r] = vec[IB + 3*T + r];
    end

`ifdef CSA_ADD_LEVEL_REG_EN
    logic [CO-1:0][OW-1:0] lvl_q;
    logic [TAG_W-1:0]      tag_q;

    always_ff @(posedge clk) begin
      if (ld_c[k+1]) begin
        lvl_q <= nxt_c[OB - M +: CO];
        tag_q <= tag_v[k];
      end
    end

    assign vec[OB +: CO] = lvl_q;
    assign tag_v[k+1]    = tag_q;
`else
    assign vec[OB +: CO] = nxt_c[OB - M +: CO];
`endif
  end

  logic [OW-1:0]    so_sum_q;
  logic [TAG_W-1:0] so_tag_q;

  always_ff @(posedge clk) begin
    if (ld_c[D-1]) begin
      so_sum_q <= vec[FB] + vec[FB + 1];
`ifdef CSA_ADD_LEVEL_REG_EN
      so_tag_q <= tag_v[L];
`else
      so_tag_q <= s0_tag_q;
`endif
    end
  end

  assign sum_out = so_sum_q;
  assign tag_out = so_tag_q;

endmodule

// File: tb/tb_csa_add_pipe.sv
// Directed and scoreboarded bench for csa_add_pipe in three operand/width configurations.
module tb_csa_add_pipe;

`ifdef CSA_ADD_LEVEL_REG_EN
  localparam int P_A = 3;
  localparam int P_B = 2;
  localparam int P_C = 7;
  localparam int D_A = 4;
`else
  localparam int P_A = 1;
  localparam int P_B = 1;
  localparam int P_C = 1;
  localparam int D_A = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: N=32, M=4 (OW=34)
  logic             a_iv, a_ir, a_cin, a_ov, a_or;
  logic [3:0][31:0] a_ops;
  logic [7:0]       a_tag, a_tago;
  logic [33:0]      a_sum;
  // B: N=8, M=3 (OW=10)
  logic             b_iv, b_ir, b_cin, b_ov, b_or;
  logic [2:0][7:0]  b_ops;
  logic [7:0]       b_tag, b_tago;
  logic [9:0]       b_sum;
  // C: N=16, M=16 (OW=20)
  logic              c_iv, c_ir, c_cin, c_ov, c_or;
  logic [15:0][15:0] c_ops;
  logic [7:0]        c_tag, c_tago;
  logic [19:0]       c_sum;

  csa_add_pipe #(.N(32), .M(4), .TAG_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .ops_in(a_ops),
    .carry_in(a_cin), .tag_in(a_tag), .out_valid(a_ov), .out_ready(a_or),
    .sum_out(a_sum), .tag_out(a_tago));

  csa_add_pipe #(.N(8), .M(3), .TAG_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .ops_in(b_ops),
    .carry_in(b_cin), .tag_in(b_tag), .out_valid(b_ov), .out_ready(b_or),
    .sum_out(b_sum), .tag_out(b_tago));

  csa_add_pipe #(.N(16), .M(16), .TAG_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .ops_in(c_ops),
    .carry_in(c_cin), .tag_in(c_tag), .out_valid(c_ov), .out_ready(c_or),
    .sum_out(c_sum), .tag_out(c_tago));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Scoreboard for DUT A: {tag, sum} in acceptance order
  logic [41:0] sb_q[$];
  logic        a_acc  = 1'b0;
  int          n_sent = 0;
  int          n_got  = 0;
  int          dir_i  = 0;
  logic [7:0]  seq    = 8'h00;

  function automatic logic [33:0] ref_a(input logic [3:0][31:0] o, input logic c);
    logic [63:0] s;
    s = 64'(c);
    for (int i = 0; i < 4; i++) s += 64'(o[i]);
    return s[33:0];
  endfunction

  task automatic a_load_beat();
    case (dir_i)
      0: begin a_ops = {32'd4, 32'd3, 32'd2, 32'd1}; a_cin = 1'b0; end
      1: begin a_ops = '0; a_cin = 1'b1; end
      2: begin a_ops = {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1}; a_cin = 1'b0; end
      default: begin
        for (int i = 0; i < 4; i++) a_ops[i] = $urandom();
        a_cin = 1'($urandom_range(0, 1));
      end
    endcase
    a_tag = seq;
    seq   = seq + 8'd1;
    dir_i++;
  endtask

  // One clock of DUT A traffic; an offered beat is held until accepted
  task automatic a_cycle(input logic offer, input logic ordy);
    @(posedge clk); #1;
    if (!(a_iv && !a_acc)) begin
      a_iv = offer;
      if (offer) a_load_beat();
    end
    a_or = ordy;
    #1;
    if (a_ov) begin
      if (sb_q.size() == 0) begin
        check("a_spurious_out", 64'(a_ov), 64'(0));
      end else begin
        check("a_out", 64'({a_tago, a_sum}), 64'(sb_q[0]));
        if (ordy) begin
          void'(sb_q.pop_front());
          n_got++;
        end
      end
    end
    a_acc = a_iv && a_ir;
    if (a_acc) begin
      sb_q.push_back({a_tag, ref_a(a_ops, a_cin)});
      n_sent++;
    end
  endtask

  task automatic a_drain();
    for (int i = 0; i < 50 && (sb_q.size() != 0 || a_iv); i++) a_cycle(1'b0, 1'b1);
    check("a_drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic wait_out(input int which, output int lat);
    lat = 0;
    while (lat < 20) begin
      if ((which == 0 && a_ov) || (which == 1 && b_ov) || (which == 2 && c_ov)) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int base;
    int got_base;
    a_iv = 0; a_or = 0; a_ops = '0; a_cin = 0; a_tag = '0;
    b_iv = 0; b_or = 0; b_ops = '0; b_cin = 0; b_tag = '0;
    c_iv = 0; c_or = 0; c_ops = '0; c_cin = 0; c_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid_a", 64'(a_ov), 64'(0));
    check("rst_out_valid_b", 64'(b_ov), 64'(0));
    check("rst_out_valid_c", 64'(c_ov), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready_a", 64'(a_ir), 64'(1));
    check("rst_in_ready_c", 64'(c_ir), 64'(1));

    // All-ones operands with carry-in
    a_ops = {4{32'hFFFF_FFFF}}; a_cin = 1'b1; a_tag = 8'h5A; a_iv = 1'b1; a_or = 1'b1;
    #1;
    check("a_first_in_ready", 64'(a_ir), 64'(1));
    @(posedge clk); #1;
    a_iv = 1'b0;
    wait_out(0, lat);
    check("a_latency", 64'(lat), 64'(P_A));
    check("a_allones_sum", 64'(a_sum), 64'h3_FFFF_FFFD);
    check("a_allones_tag", 64'(a_tago), 64'h5A);

    // Three MSB-only operands
    b_ops = {8'h80, 8'h80, 8'h80}; b_cin = 1'b0; b_tag = 8'hB3; b_iv = 1'b1; b_or = 1'b1;
    #1;
    check("b_in_ready", 64'(b_ir), 64'(1));
    @(posedge clk); #1;
    b_iv = 1'b0;
    wait_out(1, lat);
    check("b_latency", 64'(lat), 64'(P_B));
    check("b_msb_sum", 64'(b_sum), 64'h180);
    check("b_msb_tag", 64'(b_tago), 64'hB3);

    // Sixteen all-ones operands plus carry-in, then 1..16
    c_ops = {16{16'hFFFF}}; c_cin = 1'b1; c_tag = 8'hC7; c_iv = 1'b1; c_or = 1'b1;
    #1;
    check("c_in_ready", 64'(c_ir), 64'(1));
    @(posedge clk); #1;
    c_iv = 1'b0;
    wait_out(2, lat);
    check("c_latency", 64'(lat), 64'(P_C));
    check("c_allones_sum", 64'(c_sum), 64'hFFFF1);
    check("c_allones_tag", 64'(c_tago), 64'hC7);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) c_ops[i] = 16'(i + 1);
    c_cin = 1'b0; c_tag = 8'h11; c_iv = 1'b1;
    @(posedge clk); #1;
    c_iv = 1'b0;
    wait_out(2, lat);
    check("c_ramp_sum", 64'(c_sum), 64'h88);
    check("c_ramp_tag", 64'(c_tago), 64'h11);

    // 100-beat stream with random backpressure
    a_or = 1'b0;
    base = n_sent;
    got_base = n_got;
    for (int g = 0; g < 3000 && n_sent < base + 100; g++)
      a_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    check("a_stream_sent", 64'(n_sent - base), 64'(100));
    a_drain();
    check("a_stream_got", 64'(n_got - got_base), 64'(100));

    // Fill with output stalled, then release and accept in one cycle
    base = n_sent;
    got_base = n_got;
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 1'b0);
    check("a_fill_count", 64'(n_sent - base), 64'(D_A));
    check("a_full_in_ready", 64'(a_ir), 64'(0));
    check("a_full_out_valid", 64'(a_ov), 64'(1));
    a_cycle(1'b1, 1'b1);
    check("a_swap_in_ready", 64'(a_ir), 64'(1));
    check("a_swap_out_valid", 64'(a_ov), 64'(1));
    a_drain();
    check("a_fill_got", 64'(n_got - got_base), 64'(D_A + 1));

    // Reset with two beats in flight
    a_cycle(1'b1, 1'b0);
    a_cycle(1'b1, 1'b0);
    a_iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("a_rst_mid_out_valid", 64'(a_ov), 64'(0));
    sb_q.delete();
    a_acc = 1'b0;
    got_base = n_got;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    a_cycle(1'b0, 1'b1);
    check("a_post_rst_in_ready", 64'(a_ir), 64'(1));
    for (int i = 0; i < 8; i++) a_cycle(1'b0, 1'b1);
    check("a_post_rst_out_valid", 64'(a_ov), 64'(0));
    check("a_post_rst_no_output", 64'(n_got - got_base), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
